// File: rtl/vga_sync_rx.sv
// vga_sync_rx: receive side of the VGA sync interface.
//
// Monitors hsync/vsync (already in the clk domain) and recovers the pixel column and row, plus
// a visible flag. Line and frame lengths are checked against the expected timing. After the
// configured number of consecutive good frames the block reports lock.
//
// Ports:
//   clk_i          pixel clock
//   rst_ni         asynchronous reset, active-low
//   hsync_i        horizontal sync, polarity set by SYNC_ACTIVE_LOW
//   vsync_i        vertical sync, polarity set by SYNC_ACTIVE_LOW
//   locked_o       timing has matched the parameters for LOCK_FRAMES frames
//   visible_o      recovered pixel is in the active area (registered)
//   column_o       recovered column, 0 when not visible (registered)
//   row_o          recovered row, 0 when not visible (registered)
//   frame_start_o  1-clk pulse on a vsync leading edge while locked (registered)
//   err_count_o    timing errors seen in CHECK/LOCKED, saturating at 255
module vga_sync_rx #(
  parameter int unsigned H_WHOLE_LINE     = 800,
  parameter int unsigned H_VISIBLE        = 640,
  parameter int unsigned H_SYNC_TO_ACTIVE = 144,
  parameter int unsigned V_WHOLE_FRAME    = 525,
  parameter int unsigned V_VISIBLE        = 480,
  parameter int unsigned V_SYNC_TO_ACTIVE = 35,
  parameter bit          SYNC_ACTIVE_LOW  = 1'b1,
  parameter int unsigned LOCK_FRAMES      = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              hsync_i,
  input  logic                              vsync_i,
  output logic                              locked_o,
  output logic                              visible_o,
  output logic [$clog2(H_WHOLE_LINE)-1:0]   column_o,
  output logic [$clog2(V_WHOLE_FRAME)-1:0]  row_o,
  output logic                              frame_start_o,
  output logic [7:0]                        err_count_o
);

  // Counters need one extra code so they can park at the whole-line/frame value on overflow.
  localparam int unsigned HCW = $clog2(H_WHOLE_LINE + 1);
  localparam int unsigned VCW = $clog2(V_WHOLE_FRAME + 1);
  localparam int unsigned CW  = $clog2(H_WHOLE_LINE);
  localparam int unsigned RW  = $clog2(V_WHOLE_FRAME);
  localparam int unsigned GW  = $clog2(LOCK_FRAMES + 1);

  localparam logic [HCW-1:0] HMax   = HCW'(H_WHOLE_LINE);
  localparam logic [HCW-1:0] HLast  = HCW'(H_WHOLE_LINE - 1);
  localparam logic [HCW-1:0] HActLo = HCW'(H_SYNC_TO_ACTIVE);
  localparam logic [HCW-1:0] HActHi = HCW'(H_SYNC_TO_ACTIVE + H_VISIBLE);
  localparam logic [VCW-1:0] VMax   = VCW'(V_WHOLE_FRAME);
  localparam logic [VCW-1:0] VLast  = VCW'(V_WHOLE_FRAME - 1);
  localparam logic [VCW-1:0] VActLo = VCW'(V_SYNC_TO_ACTIVE);
  localparam logic [VCW-1:0] VActHi = VCW'(V_SYNC_TO_ACTIVE + V_VISIBLE);
  localparam logic [GW-1:0]  GoodTarget = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

  // Input stage: syncs registered once and normalised to active-high.
  logic hs_q, hs_prev_q, vs_q, vs_prev_q;
  logic hs_edge, vs_edge;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      hs_q      <= hsync_i ^ SYNC_ACTIVE_LOW;
      vs_q      <= vsync_i ^ SYNC_ACTIVE_LOW;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
    end
  end

  assign hs_edge = hs_q & ~hs_prev_q;
  assign vs_edge = vs_q & ~vs_prev_q;

  logic [HCW-1:0] h_count_q, h_count_d;
  logic [VCW-1:0] v_count_q, v_count_d;
  logic           line_err, frame_err, err;
  state_e         state_q, state_d;
  logic [GW-1:0]  good_q, good_d;
  logic [7:0]     err_count_q, err_count_d;
  logic           visible_q, visible_d;
  logic [CW-1:0]  column_q, column_d;
  logic [RW-1:0]  row_q, row_d;
  logic           frame_start_q, frame_start_d;

  // h_count_d is the coordinate of the pixel currently in the input register, so the output
  // register adds only one further clock of latency.
  always_comb begin
    line_err  = 1'b0;
    h_count_d = h_count_q;
    if (hs_edge) begin
      h_count_d = '0;
      line_err  = (h_count_q != HLast);
    end else if (h_count_q != HMax) begin
      h_count_d = h_count_q + HCW'(1);
      line_err  = (h_count_q == HLast);
    end
  end

  // A vsync edge wins over a simultaneous hsync edge.
  always_comb begin
    frame_err = 1'b0;
    v_count_d = v_count_q;
    if (vs_edge) begin
      v_count_d = '0;
      frame_err = (v_count_q != VLast);
    end else if (hs_edge && (v_count_q != VMax)) begin
      v_count_d = v_count_q + VCW'(1);
      frame_err = (v_count_q == VLast);
    end
  end

  assign err = line_err | frame_err;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      StSearch: begin
        if (vs_edge) begin
          state_d = StCheck;
          good_d  = '0;
        end
      end
      StCheck: begin
        if (err) begin
          state_d = StSearch;
        end else if (vs_edge) begin
          good_d = good_q + GW'(1);
          if (good_d == GoodTarget) state_d = StLocked;
        end
      end
      StLocked: begin
        if (err) state_d = StSearch;
      end
      default: state_d = StSearch;
    endcase
  end

  always_comb begin
    err_count_d = err_count_q;
    if (err && (state_q != StSearch) && (err_count_q != 8'hff)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // Outputs use the next lock state so visible/frame_start never lead or trail locked_o.
  always_comb begin
    visible_d = (state_d == StLocked) &&
                (h_count_d >= HActLo) && (h_count_d < HActHi) &&
                (v_count_d >= VActLo) && (v_count_d < VActHi);
    column_d      = visible_d ? CW'(h_count_d - HActLo) : '0;
    row_d         = visible_d ? RW'(v_count_d - VActLo) : '0;
    frame_start_d = vs_edge && (state_d == StLocked);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_count_q     <= '0;
      v_count_q     <= '0;
      state_q       <= StSearch;
      good_q        <= '0;
      err_count_q   <= '0;
      visible_q     <= 1'b0;
      column_q      <= '0;
      row_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      state_q       <= state_d;
      good_q        <= good_d;
      err_count_q   <= err_count_d;
      visible_q     <= visible_d;
      column_q      <= column_d;
      row_q         <= row_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign locked_o      = (state_q == StLocked);
  assign visible_o     = visible_q;
  assign column_o      = column_q;
  assign row_o         = row_q;
  assign frame_start_o = frame_start_q;
  assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx: an active-low and an active-high instance see the same logical sync
// stream and are both checked every clock against a frame-level reference model.
module tb_vga_sync_rx;

  localparam int H  = 16;
  localparam int HV = 8;
  localparam int HS = 4;
  localparam int V  = 10;
  localparam int VV = 6;
  localparam int VS = 2;
  localparam int LF = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hs_l, vs_l;  // logical syncs, 1 = asserted
  logic       lo_locked, lo_visible, lo_fs, hi_locked, hi_visible, hi_fs;
  logic [3:0] lo_col, lo_row, hi_col, hi_row;
  logic [7:0] lo_err, hi_err;

  always #5 clk = ~clk;

  vga_sync_rx #(
    .H_WHOLE_LINE(H), .H_VISIBLE(HV), .H_SYNC_TO_ACTIVE(HS),
    .V_WHOLE_FRAME(V), .V_VISIBLE(VV), .V_SYNC_TO_ACTIVE(VS),
    .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(LF)
  ) u_dut_lo (
    .clk_i(clk), .rst_ni(rst_n), .hsync_i(~hs_l), .vsync_i(~vs_l),
    .locked_o(lo_locked), .visible_o(lo_visible), .column_o(lo_col), .row_o(lo_row),
    .frame_start_o(lo_fs), .err_count_o(lo_err)
  );

  vga_sync_rx #(
    .H_WHOLE_LINE(H), .H_VISIBLE(HV), .H_SYNC_TO_ACTIVE(HS),
    .V_WHOLE_FRAME(V), .V_VISIBLE(VV), .V_SYNC_TO_ACTIVE(VS),
    .SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(LF)
  ) u_dut_hi (
    .clk_i(clk), .rst_ni(rst_n), .hsync_i(hs_l), .vsync_i(vs_l),
    .locked_o(hi_locked), .visible_o(hi_visible), .column_o(hi_col), .row_o(hi_row),
    .frame_start_o(hi_fs), .err_count_o(hi_err)
  );

  typedef struct packed {
    logic       locked;
    logic       visible;
    logic [3:0] col;
    logic [3:0] row;
    logic       fs;
    logic [7:0] err;
  } obs_t;

  typedef struct {
    int lines;
    int bad_line;
    int bad_len;
    bit exp_locked;
    int exp_err;
  } frame_vec_t;

  int   checks = 0;
  int   failures = 0;

  // Reference model: clocks since the last hsync edge, lines since the last vsync edge,
  // a hunting flag and a count of good frames.
  int   m_h, m_v, m_good, m_err;
  bit   m_hprev, m_vprev, m_hunt;
  obs_t exp_q[$];
  bit   rel_pending = 1'b0;

  function automatic obs_t cur_lo();
    return {lo_locked, lo_visible, lo_col, lo_row, lo_fs, lo_err};
  endfunction

  function automatic obs_t cur_hi();
    return {hi_locked, hi_visible, hi_col, hi_row, hi_fs, hi_err};
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t got lk=%0b vis=%0b col=%0d row=%0d fs=%0b err=%0d, want lk=%0b vis=%0b col=%0d row=%0d fs=%0b err=%0d",
               name, $time, got.locked, got.visible, got.col, got.row, got.fs, got.err,
               want.locked, want.visible, want.col, want.row, want.fs, want.err);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s t=%0t got %0d, want %0d", name, $time, got, want);
    end
  endtask

  // The input register holds a deasserted sample through reset, which the receiver counts as
  // one idle clock, so the clocks-since-edge count starts at 1.
  task automatic model_reset();
    m_h = 1;
    m_v = 0;
    m_hprev = 1'b0;
    m_vprev = 1'b0;
    m_hunt = 1'b1;
    m_good = 0;
    m_err = 0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  task automatic model_step(input bit hs, input bit vs, output obs_t o);
    bit hedge, vedge, err, was_hunt, lk, vis;
    hedge = hs && !m_hprev;
    vedge = vs && !m_vprev;
    m_hprev = hs;
    m_vprev = vs;
    err = 1'b0;
    // A line must be exactly H clocks; a missing edge is flagged once when H is reached.
    if (hedge) begin
      if (m_h != H - 1) err = 1'b1;
      m_h = 0;
    end else if (m_h < H) begin
      m_h++;
      if (m_h == H) err = 1'b1;
    end
    if (vedge) begin
      if (m_v != V - 1) err = 1'b1;
      m_v = 0;
    end else if (hedge && m_v < V) begin
      m_v++;
      if (m_v == V) err = 1'b1;
    end
    was_hunt = m_hunt;
    if (m_hunt) begin
      if (vedge) begin
        m_hunt = 1'b0;
        m_good = 0;
      end
    end else if (err) begin
      m_hunt = 1'b1;
    end else if (vedge && m_good < LF) begin
      m_good++;
    end
    if (!was_hunt && err && m_err < 255) m_err++;
    lk  = !m_hunt && (m_good >= LF);
    vis = lk && (m_h >= HS) && (m_h < HS + HV) && (m_v >= VS) && (m_v < VS + VV);
    o.locked  = lk;
    o.visible = vis;
    o.col     = vis ? 4'(m_h - HS) : 4'd0;
    o.row     = vis ? 4'(m_v - VS) : 4'd0;
    o.fs      = vedge && lk;
    o.err     = 8'(m_err);
  endtask

  // One clock: compare both instances with the model, then drive the next sync sample.
  task automatic tick(input bit hs, input bit vs);
    obs_t want, nxt;
    @(negedge clk);
    if (rel_pending) begin
      rst_n = 1'b1;
      rel_pending = 1'b0;
    end
    want = exp_q.pop_front();
    check_obs("model_lo", cur_lo(), want);
    check_obs("model_hi", cur_hi(), want);
    model_step(hs, vs, nxt);
    exp_q.push_back(nxt);
    hs_l = hs;
    vs_l = vs;
  endtask

  // vga_sync-style line: hsync for 2 clk at the start; vsync over lines 0-1.
  task automatic send_line(input int l, input int len);
    for (int c = 0; c < len; c++) tick(c < 2, l < 2);
  endtask

  task automatic send_frame(input int lines, input int bad_line, input int bad_len);
    for (int l = 0; l < lines; l++) send_line(l, (l == bad_line) ? bad_len : H);
  endtask

  frame_vec_t tbl[24];

  initial begin
    tbl[0]  = '{10, -1, 16, 1'b0, 0};
    tbl[1]  = '{10, -1, 16, 1'b0, 0};
    tbl[2]  = '{10, -1, 16, 1'b1, 0};  // locks on the 3rd vsync edge
    tbl[3]  = '{10,  3, 15, 1'b0, 1};  // short line
    tbl[4]  = '{10, -1, 16, 1'b0, 1};
    tbl[5]  = '{10, -1, 16, 1'b0, 1};
    tbl[6]  = '{10, -1, 16, 1'b1, 1};
    tbl[7]  = '{11, -1, 16, 1'b0, 2};  // 11-line frame
    tbl[8]  = '{10, -1, 16, 1'b0, 2};
    tbl[9]  = '{10, -1, 16, 1'b0, 2};
    tbl[10] = '{10, -1, 16, 1'b1, 2};
    tbl[11] = '{10,  4, 40, 1'b0, 3};  // hsync held off for 40 clk
    tbl[12] = '{10, -1, 16, 1'b0, 3};
    tbl[13] = '{10, -1, 16, 1'b0, 3};
    tbl[14] = '{10, -1, 16, 1'b1, 3};
    tbl[15] = '{10,  5, 17, 1'b0, 4};  // long line
    tbl[16] = '{10, -1, 16, 1'b0, 4};
    tbl[17] = '{10, -1, 16, 1'b0, 4};
    tbl[18] = '{10, -1, 16, 1'b1, 4};
    tbl[19] = '{ 9, -1, 16, 1'b1, 4};  // short frame, caught at the next vsync edge
    tbl[20] = '{10, -1, 16, 1'b0, 5};
    tbl[21] = '{10, -1, 16, 1'b0, 5};
    tbl[22] = '{10, -1, 16, 1'b0, 5};
    tbl[23] = '{10, -1, 16, 1'b1, 5};

    rst_n = 1'b0;
    hs_l = 1'b0;
    vs_l = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_obs("reset_lo", cur_lo(), '0);
    check_obs("reset_hi", cur_hi(), '0);
    rel_pending = 1'b1;
    repeat (5) tick(1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      send_frame(tbl[i].lines, tbl[i].bad_line, tbl[i].bad_len);
      check_val($sformatf("tbl%0d_locked", i), int'(lo_locked), int'(tbl[i].exp_locked));
      check_val($sformatf("tbl%0d_err", i), int'(lo_err), tbl[i].exp_err);
    end

    // First visible pixel of a locked frame: tx column c shows 2 clk later.
    send_line(0, H);
    send_line(1, H);
    for (int c = 0; c < H; c++) begin
      tick(c < 2, 1'b0);
      if (c == 5 || c == 14) check_val($sformatf("vis_off_c%0d", c), int'(lo_visible), 0);
      if (c >= 6 && c < 14) begin
        check_val($sformatf("vis_on_c%0d", c), int'(lo_visible), 1);
        check_val($sformatf("column_c%0d", c), int'(lo_col), c - 6);
        check_val($sformatf("row_c%0d", c), int'(lo_row), 0);
      end
    end
    for (int l = 3; l < V; l++) send_line(l, H);

    // Asynchronous reset in the middle of a visible line.
    send_line(0, H);
    send_line(1, H);
    send_line(2, H);
    for (int c = 0; c < 9; c++) tick(c < 2, 1'b0);
    check_val("pre_reset_visible", int'(lo_visible), 1);
    check_val("pre_reset_column", int'(lo_col), 2);
    check_val("pre_reset_row", int'(lo_row), 1);
    #2 rst_n = 1'b0;
    #1;
    check_obs("async_reset_lo", cur_lo(), '0);
    check_obs("async_reset_hi", cur_hi(), '0);
    model_reset();
    rel_pending = 1'b1;
    for (int c = 9; c < H; c++) tick(c < 2, 1'b0);
    for (int l = 4; l < V; l++) send_line(l, H);
    repeat (3) send_frame(V, -1, H);
    check_val("relock_locked", int'(lo_locked), 1);
    check_val("relock_err", int'(lo_err), 0);

    // Randomised frames with occasional bad lines, then raw sync noise.
    for (int f = 0; f < 40; f++) begin
      int pick, lines, bl, blen;
      pick  = int'($urandom_range(0, 9));
      lines = (pick == 0) ? 9 : (pick == 1) ? 11 : 10;
      bl    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
      blen  = int'($urandom_range(1, 20));
      send_frame(lines, bl, blen);
    end
    for (int k = 0; k < 300; k++) begin
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    // Every 11-line frame costs one error; the counter must stop at 255.
    for (int f = 0; f < 260; f++) send_frame(V + 1, -1, H);
    check_val("sat_err_lo", int'(lo_err), 255);
    check_val("sat_err_hi", int'(hi_err), 255);
    check_val("sat_locked", int'(lo_locked), 0);
    repeat (2) tick(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
